spwm_gate_monitor: RTL and testbench
====================================

# spwm_gate_monitor

Gate-signal monitor on the receiving end of the three-phase SPWM deadtime driver's six outputs (AH/AL, BH/BL, CH/CL). It synchronizes the gate lines into the system clock and decodes each phase leg into a drive state. Per phase it measures high time, period and the dead interval at every commutation, and latches shoot-through and deadtime-violation faults. Software or a protection block reads the measurements and uses the fault flags to disable the inverter.

## Interface
- CNT_W, 16: width of high-time and period counters (saturating)
- SYNC_STAGES, 2: flip-flop synchronizer depth on each gate input (≥2)
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, synchronous, active-low
- AH, AL, BH, BL, CH, CL  in  1 each  gate signals, asynchronous to clk
- min_deadtime  in  5  minimum legal dead interval in clk cycles; 0 disables the deadtime check
- fault_clr  in  1  one-cycle pulse; clears all latched faults
- sel  in  2  readout phase select: 0=A, 1=B, 2=C, 3 returns zeros
- meas_high  out  CNT_W  last complete high time of the selected phase
- meas_period  out  CNT_W  last complete period of the selected phase
- meas_dead  out  8  last dead interval of the selected phase
- meas_valid  out  3  per-phase one-cycle pulse when that phase's high/period registers update
- fault_shoot  out  3  latched shoot-through flag per phase
- fault_dt  out  3  latched deadtime-violation flag per phase
- fault  out  1  OR of all six fault bits

## Operation
- Each gate input passes through a SYNC_STAGES flip-flop chain. Decoding uses only the synchronized values {H,L}.
- Per-phase FSM, current state is a registered 2-bit value:
  - DEAD: H=0, L=0
  - HIGH: H=1, L=0
  - LOW: H=0, L=1
  - SHOOT: H=1, L=1
  - The next state is the decoded {H,L} every cycle. Any transition is legal; the FSM only classifies.
- A per-phase `last_drive` register holds NONE, HIGH or LOW and updates on entry to HIGH or LOW. Reset value is NONE.
- Dead counter (8 bit, saturates at 255):
  - Clears on entry to DEAD.
  - Increments each cycle while in DEAD.
  - On exit from DEAD to HIGH or LOW, the count is latched into dead_last.
  - A direct HIGH↔LOW transition with no DEAD cycle latches dead_last=0.
- Deadtime violation: on entry to HIGH with last_drive=LOW, or entry to LOW with last_drive=HIGH, if dead_last (the value being latched) < min_deadtime, set fault_dt[p]. There is no check when last_drive=NONE or when the new state equals last_drive.
- Shoot-through: any cycle in SHOOT sets fault_shoot[p]. It does not update last_drive or the counters, except that the period counter keeps running.
- High counter (CNT_W, saturating):
  - Clears on entry to HIGH.
  - Increments while in HIGH.
  - Its value is frozen into high_hold on exit from HIGH.
- Period counter (CNT_W, saturating):
  - Runs continuously.
  - On each entry to HIGH, it is copied to period_reg and reset to 1.
- meas_valid and armed:
  - On entry to HIGH, high_hold is copied to high_reg and meas_valid[p] pulses, but only if `armed[p]`.
  - armed[p] is set on the first HIGH entry after reset, so the first pulse comes at the second HIGH entry.
- Faults stay latched until fault_clr. If fault_clr coincides with a new fault condition, the new fault wins and the bit stays set.
- Readout mux: registered, selects high_reg, period_reg and dead_last of phase sel.

## Timing
- Reset: all outputs 0. FSMs in DEAD. last_drive=NONE. armed=0. All counters and registers 0. Synchronizer chains 0.
- Input-to-decoded-state latency is SYNC_STAGES cycles. Fault flags assert 1 cycle after the decoded state changes, i.e. SYNC_STAGES+1 cycles after the pad transition.
- meas_valid[p] asserts in the same cycle that high_reg/period_reg update. meas_* outputs reflect an update or a sel change 1 cycle later.
- Counts are exact in clk cycles of the synchronized signal: a gate high for N clk cycles measures N.
- Saturation: counters hold at their maximum value and do not wrap.
- Reset asserted mid-measurement discards all partial counts and returns the block to the reset state at the next clk edge.
- min_deadtime is sampled at the moment of the check. Changing it does not retroactively set or clear faults.

## Test plan
- Phase A driven HIGH 100 cycles, DEAD 10, LOW 200, DEAD 10, repeated, with min_deadtime=8. The second HIGH entry pulses meas_valid[0]. With sel=0: meas_high=100, meas_period=320, meas_dead=10. fault=0.
- Same pattern with dead intervals of 5 cycles and min_deadtime=8. fault_dt[0]=1 at the first commutation (HIGH→DEAD→LOW). fault=1. fault_shoot=0.
- BH and BL both high for 1 cycle. fault_shoot[1]=1 three cycles later. It stays set until a fault_clr pulse, then reads 0.
- fault_clr in the same cycle as a new CL/CH overlap: fault_shoot[2] remains 1.
- Phase C held HIGH for 70000 cycles, then LOW, then HIGH again. meas_high=65535 and meas_period=65535 (saturated). Direct HIGH→LOW with no dead cycle and min_deadtime=0 gives meas_dead=0 and no fault_dt.
- rst_n low for 1 cycle mid-HIGH on phase A. All outputs read 0. The next HIGH entry produces no meas_valid; the one after it does.

Source files
------------

// File: rtl/spwm_gate_monitor.sv
// spwm_gate_monitor
//   Watches the six gate lines of a three-phase SPWM deadtime driver.
//   Each line is synchronized into clk. Each phase leg is then classified
//   as DEAD, HIGH, LOW or SHOOT. Per phase the block measures:
//     - the last complete high time,
//     - the last complete period (entry to HIGH to the next entry to HIGH),
//     - the dead interval at each commutation.
//   It also latches shoot-through and deadtime-violation faults.
//
// Ports
//   clk, rst_n             system clock, synchronous active-low reset
//   AH/AL, BH/BL, CH/CL    asynchronous gate inputs (high side / low side)
//   min_deadtime[4:0]      minimum legal dead interval in clk cycles (0 = no check)
//   fault_clr              one-cycle pulse that clears all latched faults
//   sel[1:0]               readout phase select (0=A, 1=B, 2=C, 3=zeros)
//   meas_high/meas_period  last complete high time / period of the selected phase
//   meas_dead[7:0]         last dead interval of the selected phase
//   meas_valid[2:0]        per-phase pulse when that phase's high/period registers update
//   fault_shoot[2:0]       latched shoot-through flags
//   fault_dt[2:0]          latched deadtime-violation flags
//   fault                  OR of all latched fault bits
module spwm_gate_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             AH,
  input  logic             AL,
  input  logic             BH,
  input  logic             BL,
  input  logic             CH,
  input  logic             CL,
  input  logic [4:0]       min_deadtime,
  input  logic             fault_clr,
  input  logic [1:0]       sel,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_period,
  output logic [7:0]       meas_dead,
  output logic [2:0]       meas_valid,
  output logic [2:0]       fault_shoot,
  output logic [2:0]       fault_dt,
  output logic             fault
);

  // The encoding equals the synchronized {H,L} pair, so decoding is a plain cast.
  typedef enum logic [1:0] {
    ST_DEAD  = 2'b00,
    ST_LOW   = 2'b01,
    ST_HIGH  = 2'b10,
    ST_SHOOT = 2'b11
  } leg_state_t;

  typedef enum logic [1:0] {
    DRV_NONE = 2'b00,
    DRV_HIGH = 2'b01,
    DRV_LOW  = 2'b10
  } drive_t;

  logic [2:0] raw_h;
  logic [2:0] raw_l;

  assign raw_h = {CH, BH, AH};
  assign raw_l = {CL, BL, AL};

  logic [SYNC_STAGES-1:0] sync_h [3];
  logic [SYNC_STAGES-1:0] sync_l [3];

  leg_state_t state     [3];
  leg_state_t state_nxt [3];
  drive_t     last_drive [3];

  logic [2:0]            armed;
  logic [2:0][7:0]       dead_cnt;
  logic [2:0][7:0]       dead_last;
  logic [2:0][7:0]       dead_new;
  logic [2:0][CNT_W-1:0] high_cnt;
  logic [2:0][CNT_W-1:0] high_hold;
  logic [2:0][CNT_W-1:0] high_reg;
  logic [2:0][CNT_W-1:0] period_cnt;
  logic [2:0][CNT_W-1:0] period_reg;

  logic [2:0] enter_high;
  logic [2:0] enter_low;
  logic [2:0] enter_dead;
  logic [2:0] stay_high;
  logic [2:0] stay_dead;
  logic [2:0] exit_high;
  logic [2:0] dt_viol;
  logic [2:0] shoot_now;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc_dead(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  // Each gate line shifts through its own flip-flop chain. The MSB is the synchronized value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < 3; p++) begin
        sync_h[p] <= '0;
        sync_l[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        sync_h[p] <= {sync_h[p][SYNC_STAGES-2:0], raw_h[p]};
        sync_l[p] <= {sync_l[p][SYNC_STAGES-2:0], raw_l[p]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < 3; p++) state[p] <= ST_DEAD;
    end else begin
      for (int p = 0; p < 3; p++) state[p] <= state_nxt[p];
    end
  end

  // The next state is whatever the synchronized pair says. Every event is
  // found by comparing the registered state with that decoded value.
  always_comb begin
    enter_high = '0;
    enter_low  = '0;
    enter_dead = '0;
    stay_high  = '0;
    stay_dead  = '0;
    exit_high  = '0;
    dt_viol    = '0;
    shoot_now  = '0;
    dead_new   = '0;
    for (int p = 0; p < 3; p++) begin
      state_nxt[p] = leg_state_t'({sync_h[p][SYNC_STAGES-1], sync_l[p][SYNC_STAGES-1]});
      enter_high[p] = (state_nxt[p] == ST_HIGH) && (state[p] != ST_HIGH);
      enter_low[p]  = (state_nxt[p] == ST_LOW)  && (state[p] != ST_LOW);
      enter_dead[p] = (state_nxt[p] == ST_DEAD) && (state[p] != ST_DEAD);
      stay_high[p]  = (state_nxt[p] == ST_HIGH) && (state[p] == ST_HIGH);
      stay_dead[p]  = (state_nxt[p] == ST_DEAD) && (state[p] == ST_DEAD);
      exit_high[p]  = (state[p] == ST_HIGH) && (state_nxt[p] != ST_HIGH);
      shoot_now[p]  = (state_nxt[p] == ST_SHOOT);
      // A direct HIGH<->LOW swap had no dead time at all. Leaving SHOOT keeps the old value.
      if (state[p] == ST_DEAD)
        dead_new[p] = dead_cnt[p];
      else if (state[p] == ST_SHOOT)
        dead_new[p] = dead_last[p];
      if ((enter_high[p] && last_drive[p] == DRV_LOW) ||
          (enter_low[p]  && last_drive[p] == DRV_HIGH))
        dt_viol[p] = (dead_new[p] < {3'b000, min_deadtime});
    end
  end

  // Per-phase counters, measurement registers and latched faults.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed       <= '0;
      dead_cnt    <= '0;
      dead_last   <= '0;
      high_cnt    <= '0;
      high_hold   <= '0;
      high_reg    <= '0;
      period_cnt  <= '0;
      period_reg  <= '0;
      meas_valid  <= '0;
      fault_shoot <= '0;
      fault_dt    <= '0;
      for (int p = 0; p < 3; p++) last_drive[p] <= DRV_NONE;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (enter_dead[p])
          dead_cnt[p] <= 8'd1;
        else if (stay_dead[p])
          dead_cnt[p] <= sat_inc_dead(dead_cnt[p]);

        if (enter_high[p] || enter_low[p])
          dead_last[p] <= dead_new[p];

        if (enter_high[p])
          last_drive[p] <= DRV_HIGH;
        else if (enter_low[p])
          last_drive[p] <= DRV_LOW;

        if (enter_high[p])
          high_cnt[p] <= CNT_W'(1);
        else if (stay_high[p])
          high_cnt[p] <= sat_inc_cnt(high_cnt[p]);

        if (exit_high[p])
          high_hold[p] <= high_cnt[p];

        // The period restarts at 1 because the entry cycle belongs to the new period.
        if (enter_high[p]) begin
          period_cnt[p] <= CNT_W'(1);
          period_reg[p] <= period_cnt[p];
        end else begin
          period_cnt[p] <= sat_inc_cnt(period_cnt[p]);
        end

        // The first HIGH entry only arms the phase, because no complete high time exists yet.
        if (enter_high[p] && armed[p])
          high_reg[p] <= high_hold[p];
        meas_valid[p] <= enter_high[p] && armed[p];
        if (enter_high[p])
          armed[p] <= 1'b1;

        // A new fault condition beats a coincident clear.
        fault_shoot[p] <= (fault_shoot[p] & ~fault_clr) | shoot_now[p];
        fault_dt[p]    <= (fault_dt[p] & ~fault_clr) | dt_viol[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meas_high   <= '0;
      meas_period <= '0;
      meas_dead   <= '0;
    end else begin
      case (sel)
        2'd0: begin
          meas_high   <= high_reg[0];
          meas_period <= period_reg[0];
          meas_dead   <= dead_last[0];
        end
        2'd1: begin
          meas_high   <= high_reg[1];
          meas_period <= period_reg[1];
          meas_dead   <= dead_last[1];
        end
        2'd2: begin
          meas_high   <= high_reg[2];
          meas_period <= period_reg[2];
          meas_dead   <= dead_last[2];
        end
        default: begin
          meas_high   <= '0;
          meas_period <= '0;
          meas_dead   <= '0;
        end
      endcase
    end
  end

  assign fault = |{fault_shoot, fault_dt};

endmodule

// File: tb/tb_spwm_gate_monitor.sv
// tb_spwm_gate_monitor
//   Self-checking bench for spwm_gate_monitor. A behavioural model follows
//   the gate levels the bench drives. Whenever a drive should produce a
//   meas_valid pulse, the model pushes the expected measurement into a
//   scoreboard queue. A monitor pops the queue when meas_valid fires.
module tb_spwm_gate_monitor;

  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_MAX     = 65535;

  localparam logic [1:0] LVL_DEAD  = 2'b00;
  localparam logic [1:0] LVL_LOW   = 2'b01;
  localparam logic [1:0] LVL_HIGH  = 2'b10;
  localparam logic [1:0] LVL_SHOOT = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             AH = 1'b0, AL = 1'b0, BH = 1'b0, BL = 1'b0, CH = 1'b0, CL = 1'b0;
  logic [4:0]       min_deadtime = 5'd0;
  logic             fault_clr = 1'b0;
  logic [1:0]       sel = 2'd0;
  logic [CNT_W-1:0] meas_high;
  logic [CNT_W-1:0] meas_period;
  logic [7:0]       meas_dead;
  logic [2:0]       meas_valid;
  logic [2:0]       fault_shoot;
  logic [2:0]       fault_dt;
  logic             fault;

  always #10 clk = ~clk;

  spwm_gate_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .AH          (AH),
    .AL          (AL),
    .BH          (BH),
    .BL          (BL),
    .CH          (CH),
    .CL          (CL),
    .min_deadtime(min_deadtime),
    .fault_clr   (fault_clr),
    .sel         (sel),
    .meas_high   (meas_high),
    .meas_period (meas_period),
    .meas_dead   (meas_dead),
    .meas_valid  (meas_valid),
    .fault_shoot (fault_shoot),
    .fault_dt    (fault_dt),
    .fault       (fault)
  );

  typedef struct {
    int phase;
    int high;
    int period;
    int dead;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  sb_entry_t last_push [3];
  sb_entry_t pend;
  bit        pend_valid = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  logic [1:0] cur_lvl      [3];
  logic [1:0] last_drive_m [3];
  int         cur_len      [3];
  int         since_high   [3];
  int         high_len     [3];
  int         dead_last_m  [3];
  bit         armed_m      [3];
  logic [2:0] exp_shoot;
  logic [2:0] exp_dt;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic resetModel();
    for (int q = 0; q < 3; q++) begin
      cur_lvl[q]      = LVL_DEAD;
      last_drive_m[q] = LVL_DEAD;
      cur_len[q]      = 0;
      since_high[q]   = 0;
      high_len[q]     = 0;
      dead_last_m[q]  = 0;
      armed_m[q]      = 1'b0;
      last_push[q]    = '{phase: q, high: 0, period: 0, dead: 0};
    end
    exp_shoot = '0;
    exp_dt    = '0;
  endtask

  task automatic advanceModel(input int n);
    for (int q = 0; q < 3; q++) begin
      cur_len[q]    += n;
      since_high[q] += n;
    end
  endtask

  task automatic setPins(input int p, input logic h, input logic l);
    case (p)
      0: begin AH = h; AL = l; end
      1: begin BH = h; BL = l; end
      default: begin CH = h; CL = l; end
    endcase
  endtask

  // Drive phase p to {h,l} for n clock cycles, updating the model and scoreboard.
  task automatic applyStimulus(input int p, input logic h, input logic l, input int n);
    logic [1:0] new_lvl;
    int         latched;
    sb_entry_t  e;
    new_lvl = {h, l};
    if (new_lvl != cur_lvl[p]) begin
      if (cur_lvl[p] == LVL_HIGH)
        high_len[p] = cur_len[p];
      if (new_lvl == LVL_HIGH || new_lvl == LVL_LOW) begin
        if (cur_lvl[p] == LVL_DEAD)
          latched = sat(cur_len[p], 255);
        else if (cur_lvl[p] == LVL_SHOOT)
          latched = dead_last_m[p];
        else
          latched = 0;
        dead_last_m[p] = latched;
        if (last_drive_m[p] != LVL_DEAD && last_drive_m[p] != new_lvl && latched < int'(min_deadtime))
          exp_dt[p] = 1'b1;
        last_drive_m[p] = new_lvl;
      end
      if (new_lvl == LVL_HIGH) begin
        if (armed_m[p]) begin
          e = '{phase: p, high: sat(high_len[p], CNT_MAX), period: sat(since_high[p], CNT_MAX),
                dead: dead_last_m[p]};
          sb_q.push_back(e);
          last_push[p] = e;
        end
        armed_m[p]    = 1'b1;
        since_high[p] = 0;
      end
      if (new_lvl == LVL_SHOOT)
        exp_shoot[p] = 1'b1;
      cur_lvl[p] = new_lvl;
      cur_len[p] = 0;
    end
    setPins(p, h, l);
    repeat (n) @(posedge clk);
    #1;
    advanceModel(n);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
    advanceModel(n);
  endtask

  task automatic clearFaults();
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
    advanceModel(1);
    exp_shoot = '0;
    exp_dt    = '0;
  endtask

  task automatic resetDut(input int n);
    rst_n = 1'b0;
    AH = 1'b0; AL = 1'b0; BH = 1'b0; BL = 1'b0; CH = 1'b0; CL = 1'b0;
    fault_clr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    resetModel();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_meas_high"},   meas_high,   0);
    checkOutput({tag, "_meas_period"}, meas_period, 0);
    checkOutput({tag, "_meas_dead"},   meas_dead,   0);
    checkOutput({tag, "_meas_valid"},  meas_valid,  0);
    checkOutput({tag, "_fault_shoot"}, fault_shoot, 0);
    checkOutput({tag, "_fault_dt"},    fault_dt,    0);
    checkOutput({tag, "_fault"},       fault,       0);
  endtask

  task automatic checkFaults(input string tag);
    checkOutput({tag, "_fault_shoot"}, fault_shoot, exp_shoot);
    checkOutput({tag, "_fault_dt"},    fault_dt,    exp_dt);
    checkOutput({tag, "_fault"},       fault,       |{exp_shoot, exp_dt});
  endtask

  task automatic runPattern(input int p, input int hi, input int dead, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      applyStimulus(p, 1'b1, 1'b0, hi);
      applyStimulus(p, 1'b0, 1'b0, dead);
      applyStimulus(p, 1'b0, 1'b1, lo);
      applyStimulus(p, 1'b0, 1'b0, dead);
    end
  endtask

  // Scoreboard monitor. A meas_valid pulse pops one expectation.
  // The readout for the selected phase is compared one cycle later.
  initial begin
    forever begin
      @(negedge clk);
      if (pend_valid) begin
        if (pend.phase == int'(sel)) begin
          checkOutput("meas_high",   meas_high,   pend.high);
          checkOutput("meas_period", meas_period, pend.period);
          checkOutput("meas_dead",   meas_dead,   pend.dead);
        end
        pend_valid = 1'b0;
      end
      if (rst_n) begin
        for (int p = 0; p < 3; p++) begin
          if (meas_valid[p]) begin
            if (sb_q.size() == 0) begin
              checkOutput("valid_unexpected", meas_valid, 0);
            end else begin
              pend = sb_q.pop_front();
              checkOutput("valid_phase", p, pend.phase);
              pend_valid = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    resetModel();
    resetDut(3);
    checkAllZero("reset");

    // Phase A: clean commutation with enough dead time.
    sel = 2'd0;
    min_deadtime = 5'd8;
    runPattern(0, 100, 10, 200, 3);
    checkFaults("clean_a");

    // Phase A: dead time of 5 is shorter than the minimum of 8.
    applyStimulus(0, 1'b1, 1'b0, 100);
    applyStimulus(0, 1'b0, 1'b0, 5);
    applyStimulus(0, 1'b0, 1'b1, 200);
    checkFaults("short_dt_first");
    applyStimulus(0, 1'b0, 1'b0, 5);
    runPattern(0, 100, 5, 200, 1);
    checkFaults("short_dt_after");

    // Phase B: one-cycle overlap. The flag must not be set early.
    clearFaults();
    idleCycles(2);
    checkFaults("cleared");
    applyStimulus(1, 1'b1, 1'b1, 1);
    applyStimulus(1, 1'b0, 1'b0, 1);
    checkOutput("shoot_b_early", fault_shoot[1], 0);
    applyStimulus(1, 1'b0, 1'b0, 1);
    checkFaults("shoot_b_set");
    idleCycles(10);
    checkFaults("shoot_b_hold");
    clearFaults();
    idleCycles(2);
    checkFaults("shoot_b_clr");

    // Phase C overlap lands on the same edge as fault_clr. B's fault is cleared; C's stays set.
    applyStimulus(1, 1'b1, 1'b1, 1);
    applyStimulus(1, 1'b0, 1'b0, 5);
    applyStimulus(2, 1'b1, 1'b1, 1);
    applyStimulus(2, 1'b0, 1'b0, 1);
    clearFaults();
    exp_shoot[2] = 1'b1;
    idleCycles(2);
    checkFaults("clr_vs_shoot_c");
    clearFaults();
    idleCycles(2);
    checkFaults("cleared_again");

    // Phase C: counters saturate. Direct swaps give dead = 0 with the check disabled.
    sel = 2'd2;
    min_deadtime = 5'd0;
    applyStimulus(2, 1'b1, 1'b0, 70000);
    applyStimulus(2, 1'b0, 1'b1, 100);
    applyStimulus(2, 1'b1, 1'b0, 50);
    applyStimulus(2, 1'b0, 1'b0, 10);
    checkFaults("sat_c");

    // Readout mux: sel=3 gives zeros, and sel=0 returns phase A's last measurement.
    sel = 2'd3;
    idleCycles(2);
    checkOutput("sel3_high",   meas_high,   0);
    checkOutput("sel3_period", meas_period, 0);
    checkOutput("sel3_dead",   meas_dead,   0);
    sel = 2'd0;
    idleCycles(2);
    checkOutput("readback_a_high",   meas_high,   last_push[0].high);
    checkOutput("readback_a_period", meas_period, last_push[0].period);
    checkOutput("readback_a_dead",   meas_dead,   last_push[0].dead);

    // Reset asserted in the middle of a HIGH on phase A. The phase re-arms from scratch.
    min_deadtime = 5'd8;
    applyStimulus(0, 1'b1, 1'b0, 30);
    resetDut(1);
    checkAllZero("mid_reset");
    applyStimulus(0, 1'b1, 1'b0, 40);
    applyStimulus(0, 1'b0, 1'b0, 10);
    applyStimulus(0, 1'b0, 1'b1, 40);
    applyStimulus(0, 1'b0, 1'b0, 10);
    applyStimulus(0, 1'b1, 1'b0, 40);
    applyStimulus(0, 1'b0, 1'b0, 10);
    checkFaults("after_reset");

    idleCycles(5);
    checkOutput("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
